// File: rtl/cpu_cmd_core.sv
// rtl/cpu_cmd_core.sv - command-driven MBR/MDR/H register core with local memory and ALU
module cpu_cmd_core #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              done,
  output logic [DATA_W-1:0] mbr_q,
  output logic [DATA_W-1:0] mdr_q,
  output logic [DATA_W-1:0] h_q,
  output logic              zero_q,
  output logic              carry_q
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_READ = 3'd3;
  localparam logic [2:0] OP_INC  = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_AND  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_EX1, S_EX2} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [DATA_W-1:0]   r_b_mdr;
  logic [DATA_W-1:0]   r_b_h;
  logic [DATA_W-1:0]   r_mbr;
  logic [DATA_W-1:0]   r_mdr;
  logic [DATA_W-1:0]   r_h;
  logic                r_zero;
  logic                r_carry;
  logic                r_done;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic                w_two_cycle;
  logic                w_ex1_commit;
  logic                w_ex2_commit;
  logic [DATA_W:0]     w_alu;
  logic [DATA_W-1:0]   w_alu_res;

  // Opcodes from READ upward all take the second execute cycle.
  assign w_two_cycle = (r_op >= OP_READ);
  assign w_alu_res   = w_alu[DATA_W-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic and per-state strobes; ready only while idle.
  always_comb begin
    w_next       = r_state;
    cmd_ready    = 1'b0;
    w_accept     = 1'b0;
    w_ex1_commit = 1'b0;
    w_ex2_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept = 1'b1;
          w_next   = S_EX1;
        end
      end
      S_EX1: begin
        if (w_two_cycle) begin
          w_next = S_EX2;
        end else begin
          w_next       = S_IDLE;
          w_ex1_commit = 1'b1;
        end
      end
      S_EX2: begin
        w_next       = S_IDLE;
        w_ex2_commit = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ALU on the B-bus copies; the extra MSB carries carry-out or borrow.
  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_INC:  w_alu = {1'b0, r_b_mdr} + {{DATA_W{1'b0}}, 1'b1};
      OP_ADD:  w_alu = {1'b0, r_b_h} + {1'b0, r_b_mdr};
      OP_SUB:  w_alu = {1'b0, r_b_h} - {1'b0, r_b_mdr};
      OP_AND:  w_alu = {1'b0, r_b_h & r_b_mdr};
      default: w_alu = '0;
    endcase
  end

  // Latch the command fields at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= OP_NOP;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_op   <= cmd_op;
      r_addr <= cmd_addr;
      r_data <= cmd_data;
    end
  end

  // Register file, B bus, flags and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr <= '0;
      r_b_mdr   <= '0;
      r_b_h     <= '0;
      r_mbr     <= '0;
      r_mdr     <= '0;
      r_h       <= '0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_ex1_commit) begin
        r_done <= 1'b1;
        if (r_op == OP_LOAD) r_mbr <= r_data;
      end
      if (r_state == S_EX1 && w_two_cycle) begin
        r_rd_addr <= r_addr;
        r_b_mdr   <= r_mdr;
        r_b_h     <= r_h;
      end
      if (w_ex2_commit) begin
        r_done <= 1'b1;
        if (r_op == OP_READ) begin
          r_mdr <= r_mem[r_rd_addr];
        end else begin
          r_mbr   <= w_alu_res;
          r_zero  <= (w_alu_res == '0);
          r_carry <= w_alu[DATA_W];
          if (r_op == OP_INC) r_h <= w_alu_res;
        end
      end
    end
  end

  // Local memory; only a WRITE committing out of EX1 stores MBR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_ex1_commit && r_op == OP_WRITE) begin
      r_mem[r_addr] <= r_mbr;
    end
  end

  assign done    = r_done;
  assign mbr_q   = r_mbr;
  assign mdr_q   = r_mdr;
  assign h_q     = r_h;
  assign zero_q  = r_zero;
  assign carry_q = r_carry;

endmodule

// File: tb/tb_cpu_cmd_core.sv
// tb/tb_cpu_cmd_core.sv - directed self-checking bench for cpu_cmd_core
module tb_cpu_cmd_core;

  localparam logic [2:0] NOP = 3'd0, LD = 3'd1, WR = 3'd2, RD = 3'd3,
                         INC = 3'd4, ADD = 3'd5, SUB = 3'd6, ANDOP = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       va = 1'b0;
  logic       vb = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [5:0] cmd_addr = 6'd0;
  logic [7:0] cmd_data = 8'd0;

  logic       a_ready, a_done, a_zero, a_carry;
  logic [3:0] a_mbr, a_mdr, a_h;
  logic       b_ready, b_done, b_zero, b_carry;
  logic [7:0] b_mbr, b_mdr, b_h;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_cmd_core #(.DATA_W(4), .ADDR_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(va), .cmd_ready(a_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr[3:0]), .cmd_data(cmd_data[3:0]),
    .done(a_done), .mbr_q(a_mbr), .mdr_q(a_mdr), .h_q(a_h),
    .zero_q(a_zero), .carry_q(a_carry)
  );

  cpu_cmd_core #(.DATA_W(8), .ADDR_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(vb), .cmd_ready(b_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .done(b_done), .mbr_q(b_mbr), .mdr_q(b_mdr), .h_q(b_h),
    .zero_q(b_zero), .carry_q(b_carry)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic run_cmd(input bit sel_b, input logic [2:0] op,
                         input logic [5:0] addr, input logic [7:0] data);
    int   n;
    bit   two;
    logic d;
    two      = (op >= RD);
    cmd_op   = op;
    cmd_addr = addr;
    cmd_data = data;
    if (sel_b) vb = 1'b1; else va = 1'b1;
    check("ready_at_issue", sel_b ? b_ready : a_ready, 1);
    @(posedge clk);
    #1;
    va = 1'b0;
    vb = 1'b0;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
      d = sel_b ? b_done : a_done;
    end while (!d && n < 8);
    check(two ? "latency_2cyc" : "latency_1cyc", n, two ? 3 : 2);
    check("ready_in_done", sel_b ? b_ready : a_ready, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", a_ready, 1);
    check("rst_done", a_done, 0);
    check("rst_regs", {a_mbr, a_mdr, a_h, a_zero, a_carry}, 0);

    // Load, write, read back
    run_cmd(0, LD, 6'd0, 8'd1);   check("ld1_mbr", a_mbr, 1);
    run_cmd(0, WR, 6'd1, 8'd0);   check("wr1_mbr", a_mbr, 1);
    run_cmd(0, RD, 6'd1, 8'd0);   check("rd1_mdr", a_mdr, 1);

    // INC / ADD chain with back-to-back write/read
    run_cmd(0, INC, 6'd0, 8'd0);
    check("inc_h", a_h, 2);       check("inc_mbr", a_mbr, 2);
    run_cmd(0, WR, 6'd2, 8'd0);
    run_cmd(0, RD, 6'd2, 8'd0);   check("rd2_mdr", a_mdr, 2);
    run_cmd(0, ADD, 6'd0, 8'd0);  check("add_mbr", a_mbr, 4);
    check("add_h_hold", a_h, 2);
    run_cmd(0, WR, 6'd4, 8'd0);
    run_cmd(0, RD, 6'd4, 8'd0);   check("rd4_mdr", a_mdr, 4);
    check("add_zero", a_zero, 0); check("add_carry", a_carry, 0);

    // Wrap-around, borrow, AND, flag hold on NOP
    run_cmd(0, LD, 6'd0, 8'd15);
    run_cmd(0, WR, 6'd0, 8'd0);
    run_cmd(0, RD, 6'd0, 8'd0);   check("rd0_mdr", a_mdr, 15);
    run_cmd(0, INC, 6'd0, 8'd0);
    check("wrap_mbr", a_mbr, 0);  check("wrap_h", a_h, 0);
    check("wrap_zero", a_zero, 1); check("wrap_carry", a_carry, 1);
    run_cmd(0, SUB, 6'd0, 8'd0);
    check("sub_mbr", a_mbr, 1);   check("sub_borrow", a_carry, 1);
    check("sub_zero", a_zero, 0);
    run_cmd(0, ANDOP, 6'd0, 8'd0);
    check("and_mbr", a_mbr, 0);   check("and_zero", a_zero, 1);
    check("and_carry", a_carry, 0);
    run_cmd(0, NOP, 6'd0, 8'd0);
    check("nop_zero_hold", a_zero, 1); check("nop_mbr_hold", a_mbr, 0);

    // Command held during EX1/EX2 is ignored until IDLE
    @(negedge clk);
    cmd_op = RD; cmd_addr = 6'd4; va = 1'b1;
    @(posedge clk);
    #1;
    cmd_op = LD; cmd_data = 8'd9;
    @(negedge clk);
    check("busy_ex1_ready", a_ready, 0); check("busy_ex1_mbr", a_mbr, 0);
    @(negedge clk);
    check("busy_ex2_ready", a_ready, 0); check("busy_ex2_mbr", a_mbr, 0);
    @(negedge clk);
    check("busy_done", a_done, 1);  check("busy_rd_mdr", a_mdr, 4);
    check("busy_mbr_still", a_mbr, 0);
    @(posedge clk);
    #1;
    va = 1'b0;
    @(negedge clk);
    check("held_ex1_done", a_done, 0);
    @(negedge clk);
    check("held_done", a_done, 1);  check("held_mbr", a_mbr, 9);

    // Reset in EX1 of WRITE 7 -> addr 3 aborts it
    run_cmd(0, LD, 6'd0, 8'd7);
    cmd_op = WR; cmd_addr = 6'd3; va = 1'b1;
    @(posedge clk);
    #1;
    va = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_regs", {a_mbr, a_mdr, a_h, a_zero, a_carry}, 0);
    @(negedge clk);
    check("abort_done", a_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_done", a_done, 0); check("abort_ready", a_ready, 1);
    run_cmd(0, NOP, 6'd0, 8'd0);
    run_cmd(0, LD, 6'd0, 8'd5);
    run_cmd(0, RD, 6'd3, 8'd0);   check("abort_mem3", a_mdr, 0);

    // Wide instance: DATA_W=8, ADDR_W=6
    run_cmd(1, LD, 6'd0, 8'd200);
    run_cmd(1, WR, 6'd63, 8'd0);
    run_cmd(1, RD, 6'd63, 8'd0);  check("w_rd63_mdr", b_mdr, 200);
    run_cmd(1, INC, 6'd0, 8'd0);
    check("w_inc_mbr", b_mbr, 201); check("w_inc_h", b_h, 201);
    check("w_inc_carry", b_carry, 0); check("w_inc_zero", b_zero, 0);
    @(negedge clk);
    check("w_done_pulse", b_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_cmd_core.md
CPU_CMD_CORE -- requirements
Module: cpu_cmd_core

Interface
REQ-001 Parameter DATA_W, default 4, width of the data path, the MBR/MDR/H registers and the memory words.
REQ-002 Parameter ADDR_W, default 4, memory address width; depth SHALL be 2**ADDR_W words.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_op  input  3  opcode: 0 NOP, 1 LOAD_MBR, 2 WRITE, 3 READ, 4 INC, 5 ADD, 6 SUB, 7 AND.
REQ-008 cmd_addr  input  ADDR_W  memory address for WRITE/READ.
REQ-009 cmd_data  input  DATA_W  immediate for LOAD_MBR.
REQ-010 done  output  1  one-cycle pulse on command completion.
REQ-011 mbr_q, mdr_q, h_q  output  DATA_W each  current MBR, MDR and H register values.
REQ-012 zero_q  output  1  zero flag of the last ALU op; carry_q  output  1  carry/borrow of the last ALU op.

Function
REQ-013 Acceptance: a command SHALL be accepted at a rising edge where cmd_valid=1 and cmd_ready=1; op, addr and data SHALL be latched at that edge.
REQ-014 cmd_ready SHALL be 1 only in state IDLE; cmd_valid while not ready SHALL be ignored, with no queueing.
REQ-015 FSM states: IDLE, EX1, EX2; IDLE->EX1 on acceptance; EX1->IDLE for 1-cycle ops (NOP, LOAD_MBR, WRITE); EX1->EX2->IDLE for 2-cycle ops (READ, INC, ADD, SUB, AND).
REQ-016 Latency: with acceptance at edge k, a 1-cycle op SHALL commit at edge k+1 and a 2-cycle op SHALL commit at edge k+2; done SHALL be 1 for exactly the cycle after the commit edge, and cmd_ready SHALL be 1 in that same cycle.
REQ-017 NOP: no register, memory or flag change; done pulses.
REQ-018 LOAD_MBR: MBR <= cmd_data.
REQ-019 WRITE: mem[cmd_addr] <= MBR; MBR unchanged.
REQ-020 READ: the address SHALL be registered in EX1 and MDR <= mem[addr] at the EX2 exit edge; this is the 2-clock read.
REQ-021 INC: MDR and H SHALL be sampled onto the internal B bus in EX1; at EX2 exit MBR <= MDR+1 and H <= MDR+1, both modulo 2**DATA_W.
REQ-022 ADD: MBR <= H+MDR; SUB: MBR <= H-MDR; AND: MBR <= H&MDR; all modulo 2**DATA_W, H unchanged.
REQ-023 Flags SHALL update only at ALU commit (INC/ADD/SUB/AND): zero_q=1 iff the result is 0; carry_q = carry-out for INC/ADD, borrow (H<MDR unsigned) for SUB, 0 for AND; other ops hold the flags.
REQ-024 Wrap-around: INC with MDR all-ones SHALL give 0 with zero_q=1 and carry_q=1.
REQ-025 Back-to-back: a READ accepted in the done cycle of a WRITE to the same address SHALL return the newly written value.
REQ-026 The full address range 0..2**ADDR_W-1 SHALL be valid; there is no out-of-range case.

Reset
REQ-027 When rst_n=0: FSM to IDLE; MBR, MDR, H, zero_q, carry_q, done and all memory words to 0; cmd_ready=1 after reset is released.
REQ-028 Reset asserted mid-command SHALL abort it: no memory write, no register commit, no done pulse.

Verification
REQ-029 LOAD_MBR 1; WRITE addr 1; READ addr 1 -> mbr_q=1; mem[1]=1; mdr_q=1 two edges after READ acceptance; one done pulse per command.
REQ-030 After REQ-029: INC; WRITE addr 2; READ addr 2; ADD; WRITE addr 4; READ addr 4 -> h_q=2, mbr_q=2 after INC; mdr_q=2; mbr_q=4 after ADD; final mdr_q=4, zero_q=0, carry_q=0.
REQ-031 DATA_W=4: LOAD_MBR 15, WRITE 0, READ 0, INC -> mbr_q=0, h_q=0, zero_q=1, carry_q=1; then SUB with H=0 and MDR=15 -> mbr_q=1, carry_q=1.
REQ-032 Hold cmd_valid high with a new command during EX1/EX2 -> cmd_ready=0 and the command is ignored; it is accepted only at the first IDLE edge.
REQ-033 Drop rst_n during EX1 of a WRITE of 7 to addr 3 -> mem[3]=0, all outputs 0, no done pulse; after release the next NOP completes normally.
REQ-034 Instantiate DATA_W=8, ADDR_W=6: LOAD_MBR 200, WRITE 63, READ 63, INC -> mdr_q=200, mbr_q=201, carry_q=0.
